imem_port_arbiter: RTL

Shares one single-ported 64×32 instruction/data memory between the fetch stage (IF) and the data stage (MEM) of the pipelined RISC-V core. It makes a combinational grant each cycle, generates stall signals for the losing requester and byte-write masks for stores, and bounds fetch starvation. It also latches a halt when the fetch port returns ECALL (32'h00000073). It sits between the pipeline stages and the memory array: read is combinational, write is synchronous.

---
 rtl/imem_port_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - single-port memory arbiter between fetch (IF) and data (MEM) stages
//
// Purpose:
//   A 64x32 memory with one port is shared between instruction fetch and the
//   data stage. Each cycle this block grants the port, stalls the losing
//   requester and formats store lanes. It also keeps fetch from starving and
//   latches a halt when fetch returns ECALL. Read data is combinational and
//   writes commit at the array's clock edge.
//
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   if_req, if_addr            fetch request and byte address (PC)
//   if_rdata/valid/stall/err   fetch response, stall and misalignment flag
//   d_req, d_we, d_size        data request, store select, size (0 byte, 1 half, 2 word)
//   d_addr, d_wdata            data byte address, right-aligned store data
//   d_rdata/valid/stall/err    data response, stall and misalignment flag
//   mem_addr/we/wmask/wdata    word-addressed array port
//   mem_rdata                  combinational array read data
//   halted                     sticky: ECALL fetched, fetch port closed
//   conflict_cnt               saturating count of cycles where both ports were eligible

module imem_port_arbiter #(
    parameter int ADDR_W          = 6,
    parameter int MAX_DATA_STREAK = 3,
    parameter int CNT_W           = 16
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req,
    input  logic [ADDR_W+1:0]   if_addr,
    output logic [31:0]         if_rdata,
    output logic                if_valid,
    output logic                if_stall,
    output logic                if_err,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [1:0]          d_size,
    input  logic [ADDR_W+1:0]   d_addr,
    input  logic [31:0]         d_wdata,
    output logic [31:0]         d_rdata,
    output logic                d_valid,
    output logic                d_stall,
    output logic                d_err,

    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [3:0]          mem_wmask,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,

    output logic                halted,
    output logic [CNT_W-1:0]    conflict_cnt
);

    localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

    // streak must hold MAX_DATA_STREAK itself; keep at least two bits.
    localparam int STREAK_BITS = $clog2(MAX_DATA_STREAK + 1);
    localparam int STREAK_W    = (STREAK_BITS < 2) ? 2 : STREAK_BITS;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak;

    logic if_elig;
    logic if_misal;
    logic d_aligned;
    logic d_elig;
    logic d_misal;
    logic grant_if;
    logic grant_d;
    logic both_elig;

    // ------------------------------------------------------------------
    // Eligibility and grant
    // ------------------------------------------------------------------
    always_comb begin
        d_aligned = 1'b0;
        case (d_size)
            2'd0:    d_aligned = 1'b1;
            2'd1:    d_aligned = ~d_addr[0];
            2'd2:    d_aligned = (d_addr[1:0] == 2'b00);
            default: d_aligned = 1'b0;
        endcase
    end

    always_comb begin
        // A halted fetch port is closed entirely: it is neither eligible nor
        // reported as misaligned, it simply stalls.
        if_elig   = if_req && !halted && (if_addr[1:0] == 2'b00);
        if_misal  = if_req && !halted && (if_addr[1:0] != 2'b00);
        d_elig    = d_req && d_aligned;
        d_misal   = d_req && !d_aligned;
        both_elig = if_elig && d_elig;

        // Data has priority, except once it has beaten fetch
        // MAX_DATA_STREAK times in a row.
        grant_d   = d_elig && (!if_elig || (streak != STREAK_MAX));
        grant_if  = if_elig && !grant_d;
    end

    // ------------------------------------------------------------------
    // Port responses and array drive
    // ------------------------------------------------------------------
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

    always_comb begin
        if_valid  = 1'b0;
        if_stall  = 1'b0;
        if_err    = 1'b0;
        d_valid   = 1'b0;
        d_stall   = 1'b0;
        d_err     = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wmask = 4'b0000;
        mem_wdata = 32'h0000_0000;

        // Everything is held quiet while reset is asserted so a store in
        // flight cannot reach the array.
        if (rst_n) begin
            if_valid = grant_if || if_misal;
            if_err   = if_misal;
            if_stall = (if_elig && !grant_if) || (halted && if_req);

            d_valid  = grant_d || d_misal;
            d_err    = d_misal;
            d_stall  = d_elig && !grant_d;

            mem_addr = grant_d ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];

            if (grant_d && d_we) begin
                mem_we = 1'b1;
                case (d_size)
                    2'd0: begin
                        mem_wmask = 4'b0001 << d_addr[1:0];
                        mem_wdata = {4{d_wdata[7:0]}};
                    end
                    2'd1: begin
                        mem_wmask = 4'b0011 << d_addr[1:0];
                        mem_wdata = {2{d_wdata[15:0]}};
                    end
                    default: begin
                        mem_wmask = 4'b1111;
                        mem_wdata = d_wdata;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // State: starvation streak, halt latch, conflict counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak       <= '0;
            halted       <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            if (grant_d && if_elig) begin
                if (streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
            end else begin
                streak <= '0;
            end

            if (grant_if && (mem_rdata == ECALL_INSN)) begin
                halted <= 1'b1;
            end

            if (both_elig && (conflict_cnt != {CNT_W{1'b1}})) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

endmodule
